fft_ram_streamer: RTL and testbench

Read-side initiator for the 16-bit-word FFT sample RAM. It walks a block of complex samples stored as interleaved pairs (real at even offset, imaginary at the next word) and issues one dual-word read per sample. It absorbs the RAM's one-cycle registered read latency and presents the samples on a valid/ready stream to the FFT datapath. Full throughput is one complex sample per cycle, and back-pressure never drops data.

---
 rtl/fft_ram_streamer_pkg.sv | 40 ++++
 rtl/fft_strm_fifo.sv | 81 ++++++++
 rtl/fft_ram_streamer.sv | 190 +++++++++++++++++++
 tb/tb_fft_ram_streamer.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_ram_streamer_pkg.sv
// -----------------------------------------------------------------------------
// fft_ram_streamer_pkg
// Shared types and constants for the FFT sample-RAM read streamer.
//   fft_strm_state_t : streamer control states (IDLE / RUN / DRAIN)
//   FFT_WORD_W       : sample component width (16)
//   FFT_ADDR_W       : RAM word-address width (16)
//   fft_cplx_t       : complex sample {re, im}
//   bitrev_low()     : reverse the low n bits of an index, upper bits unchanged
// -----------------------------------------------------------------------------
package fft_ram_streamer_pkg;

    localparam int unsigned FFT_WORD_W = 16;
    localparam int unsigned FFT_ADDR_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fft_strm_state_t;

    typedef struct packed {
        logic [FFT_WORD_W-1:0] re;
        logic [FFT_WORD_W-1:0] im;
    } fft_cplx_t;

    function automatic logic [FFT_ADDR_W-1:0] bitrev_low(
        input logic [FFT_ADDR_W-1:0] k,
        input int unsigned           n
    );
        logic [FFT_ADDR_W-1:0] r;
        r = k;
        for (int unsigned i = 0; i < FFT_ADDR_W; i++) begin
            if (i < n) begin
                r[4'(i)] = k[4'(n - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_strm_fifo.sv
// -----------------------------------------------------------------------------
// fft_strm_fifo
// Small synchronous FIFO of complex samples plus a "last" flag. Head entry is
// presented combinationally; occupancy is exported so the caller can run
// credit-based flow control.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data/push_last
//   push_data  : {re, im} packed as fft_cplx_t
//   push_last  : last-sample marker
//   pop        : advance the head (caller guarantees non-empty)
//   head_data  : head entry {re, im}
//   head_last  : head entry last marker
//   empty      : no entries
//   occ        : number of entries held
// -----------------------------------------------------------------------------
module fft_strm_fifo
    import fft_ram_streamer_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [2*FFT_WORD_W-1:0]       push_data,
    input  logic                          push_last,
    input  logic                          pop,
    output logic [2*FFT_WORD_W-1:0]       head_data,
    output logic                          head_last,
    output logic                          empty,
    output logic [$clog2(DEPTH+1)-1:0]    occ
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    typedef struct packed {
        fft_cplx_t s;
        logic      last;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [OCC_W-1:0]  occ_q;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= '{s: fft_cplx_t'(push_data), last: push_last};
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign head_data = mem_q[rd_ptr_q].s;
    assign head_last = mem_q[rd_ptr_q].last;
    assign empty     = (occ_q == '0);
    assign occ       = occ_q;

    // A push into a full FIFO without a simultaneous pop would lose data.
    overflow_check: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (occ_q == OCC_W'(DEPTH))));

endmodule

// File: rtl/fft_ram_streamer.sv
// -----------------------------------------------------------------------------
// fft_ram_streamer
// Read-side initiator for the 16-bit FFT sample RAM. Walks a block of
// interleaved complex samples (re at even word, im at next word), issues one
// dual-word read per sample, absorbs the RAM's one-cycle read latency and
// streams the samples out on valid/ready without ever dropping data.
//
// Optional build macro: FFT_STREAMER_BITREV_EN
//   defined   -> address index is bitrev(k[LOG2N-1:0]) with upper k bits kept
//   undefined -> linear index, LOG2N unused
//
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   start_i, base_i,      : block request (ignored while busy), base word
//   count_i                 address and number of complex samples
//   busy_o, done_o        : block active / one-cycle completion pulse
//   ram_en_o, ram_we_o,   : RAM request (write side tied off)
//   ram_addr_o, ram_data_o
//   ram_a_i, ram_b_i      : RAM read data, port A = addr, port B = addr+1
//   s_valid_o, s_ready_i, : sample stream
//   s_re_o, s_im_o, s_last_o
// -----------------------------------------------------------------------------
module fft_ram_streamer
    import fft_ram_streamer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned LOG2N      = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [FFT_ADDR_W-1:0] base_i,
    input  logic [FFT_ADDR_W-1:0] count_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  ram_en_o,
    output logic                  ram_we_o,
    output logic [FFT_ADDR_W-1:0] ram_addr_o,
    output logic [31:0]           ram_data_o,
    input  logic [31:0]           ram_a_i,
    input  logic [31:0]           ram_b_i,
    output logic                  s_valid_o,
    input  logic                  s_ready_i,
    output logic [FFT_WORD_W-1:0] s_re_o,
    output logic [FFT_WORD_W-1:0] s_im_o,
    output logic                  s_last_o
);

    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);

    fft_strm_state_t state_q, state_d;

    logic [FFT_ADDR_W-1:0] base_q;
    logic [FFT_ADDR_W-1:0] count_q;
    logic [FFT_ADDR_W-1:0] k_q;
    logic [FFT_ADDR_W-1:0] last_addr_q;
    logic                  inflight_q;
    logic                  inflight_last_q;
    logic                  zero_done_q;

    logic                  issue;
    logic                  drain_done;
    logic                  pop;
    logic                  accept;
    logic                  is_last_k;
    logic [OCC_W:0]        credit_used;
    logic [FFT_ADDR_W-1:0] idx;
    logic [FFT_ADDR_W-1:0] issue_addr;

    logic                  fifo_empty;
    logic [OCC_W-1:0]      occ;
    logic [2*FFT_WORD_W-1:0] head_data;
    logic                  head_last;
    fft_cplx_t             head_s;
    fft_cplx_t             push_s;

    logic                  unused_bits;

    assign accept    = (state_q == ST_IDLE) && start_i && (count_i != '0);
    assign is_last_k = (k_q == count_q - 1'b1);
    assign pop       = s_valid_o && s_ready_i;

`ifdef FFT_STREAMER_BITREV_EN
    assign idx = bitrev_low(k_q, LOG2N);
`else
    localparam int unsigned UNUSED_LOG2N = LOG2N;
    assign idx = k_q;
`endif

    assign issue_addr = base_q + {idx[FFT_ADDR_W-2:0], 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Credit counts entries held plus the read returning this cycle, less the
    // entry leaving this cycle, so a read is issued only if it has a slot.
    always_comb begin
        state_d     = state_q;
        issue       = 1'b0;
        drain_done  = 1'b0;
        credit_used = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_q}
                    - {{OCC_W{1'b0}}, pop};
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (credit_used < (OCC_W+1)'(FIFO_DEPTH)) begin
                    issue = 1'b1;
                    if (is_last_k) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_empty && !inflight_q) begin
                    drain_done = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q          <= '0;
            count_q         <= '0;
            k_q             <= '0;
            last_addr_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            zero_done_q     <= 1'b0;
        end else begin
            zero_done_q     <= (state_q == ST_IDLE) && start_i && (count_i == '0);
            inflight_q      <= issue;
            inflight_last_q <= issue && is_last_k;
            if (accept) begin
                base_q  <= base_i;
                count_q <= count_i;
                k_q     <= '0;
            end else if (issue) begin
                k_q <= k_q + 1'b1;
            end
            if (issue) begin
                last_addr_q <= issue_addr;
            end
        end
    end

    assign push_s = '{re: ram_a_i[FFT_WORD_W-1:0], im: ram_b_i[FFT_WORD_W-1:0]};

    fft_strm_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (push_s),
        .push_last (inflight_last_q),
        .pop       (pop),
        .head_data (head_data),
        .head_last (head_last),
        .empty     (fifo_empty),
        .occ       (occ)
    );

    assign head_s     = fft_cplx_t'(head_data);
    assign s_valid_o  = !fifo_empty;
    assign s_re_o     = head_s.re;
    assign s_im_o     = head_s.im;
    assign s_last_o   = head_last;

    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = zero_done_q || drain_done;
    assign ram_en_o   = issue;
    assign ram_addr_o = issue ? issue_addr : last_addr_q;
    assign ram_we_o   = 1'b0;
    assign ram_data_o = '0;

    assign unused_bits = ^{ram_a_i[31:FFT_WORD_W], ram_b_i[31:FFT_WORD_W]};

endmodule

// File: tb/tb_fft_ram_streamer.sv
`timescale 1ns/1ps
module tb_fft_ram_streamer;

    localparam int DEPTH = 2;
`ifdef FFT_STREAMER_BITREV_EN
    localparam int TB_LOG2N = 3;
`else
    localparam int TB_LOG2N = 10;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [15:0] base_i;
    logic [15:0] count_i;
    logic        busy_o, done_o, ram_en_o, ram_we_o;
    logic [15:0] ram_addr_o;
    logic [31:0] ram_data_o;
    logic [31:0] ram_a, ram_b;
    logic        s_valid_o, s_ready_i, s_last_o;
    logic [15:0] s_re_o, s_im_o;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [65536];
    logic [15:0] last_addr_seen;
    logic [15:0] got_addr [$];

    always #5 clk = ~clk;

    // Registered dual-port read RAM; upper data bits carry junk.
    always @(posedge clk) begin
        if (ram_en_o) begin
            ram_a <= {16'($urandom), mem[ram_addr_o]};
            ram_b <= {16'($urandom), mem[16'(ram_addr_o + 16'd1)]};
        end
    end

    fft_ram_streamer #(
        .FIFO_DEPTH(DEPTH),
        .LOG2N     (TB_LOG2N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .base_i    (base_i),
        .count_i   (count_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .ram_en_o  (ram_en_o),
        .ram_we_o  (ram_we_o),
        .ram_addr_o(ram_addr_o),
        .ram_data_o(ram_data_o),
        .ram_a_i   (ram_a),
        .ram_b_i   (ram_b),
        .s_valid_o (s_valid_o),
        .s_ready_i (s_ready_i),
        .s_re_o    (s_re_o),
        .s_im_o    (s_im_o),
        .s_last_o  (s_last_o)
    );

    // Reference address for sample k: base + 2*index, index optionally
    // bit-reversed in its low TB_LOG2N bits, all modulo 2^16.
    function automatic logic [15:0] model_addr(input logic [15:0] base, input int k);
        int idx = k;
`ifdef FFT_STREAMER_BITREV_EN
        int lo  = k % (1 << TB_LOG2N);
        int rev = 0;
        for (int b = 0; b < TB_LOG2N; b++) begin
            if (((lo >> b) & 1) == 1) rev = rev + (1 << (TB_LOG2N - 1 - b));
        end
        idx = k - lo + rev;
`endif
        return 16'((int'(base) + 2 * idx) % 65536);
    endfunction

    function automatic logic pick_ready(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 3 == 0);
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_block(input logic [15:0] base, input logic [15:0] cnt,
                             input int mode, input bit exact, input bit noise);
        logic [15:0] exp_addr [$];
        logic [15:0] exp_re [$];
        logic [15:0] exp_im [$];
        logic [15:0] a;
        int n = int'(cnt);
        int issued = 0, popped = 0, last_hs = -100;
        int first_en = -1, first_valid = -1, done_cyc = -1;
        int budget = 40 + 6 * n;
        bit held = 0, finished = 0;
        logic [15:0] h_re, h_im;
        logic h_last;

        got_addr.delete();
        for (int k = 0; k < n; k++) begin
            a = model_addr(base, k);
            exp_addr.push_back(a);
            exp_re.push_back(mem[a]);
            exp_im.push_back(mem[16'(a + 16'd1)]);
        end

        @(posedge clk); #1;
        start_i = 1'b1; base_i = base; count_i = cnt; s_ready_i = pick_ready(mode, 0);
        @(negedge clk);
        total++;
        if (busy_o !== 1'b0 || ram_en_o !== 1'b0 || done_o !== 1'b0) begin
            bad++;
            $display("FAIL idle_at_start busy=%b en=%b done=%b required 0 0 0", busy_o, ram_en_o, done_o);
        end

        for (int cyc = 1; cyc <= budget && !finished; cyc++) begin
            @(posedge clk); #1;
            start_i = (noise && n != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) begin base_i = 16'($urandom); count_i = 16'($urandom); end
            s_ready_i = pick_ready(mode, cyc);
            @(negedge clk);

            total++;
            if (busy_o !== (n != 0) || ram_we_o !== 1'b0 || ram_data_o !== 32'h0) begin
                bad++;
                $display("FAIL busy_tie cyc=%0d busy=%b we=%b data=%h required busy=%b we=0 data=0",
                         cyc, busy_o, ram_we_o, ram_data_o, (n != 0));
            end

            total++;
            if (ram_en_o) begin
                if (first_en < 0) first_en = cyc;
                got_addr.push_back(ram_addr_o);
                if (issued >= n) begin
                    bad++;
                    $display("FAIL extra_issue cyc=%0d addr=%h issued=%0d required count=%0d", cyc, ram_addr_o, issued, n);
                end else if (ram_addr_o !== exp_addr[issued]) begin
                    bad++;
                    $display("FAIL addr k=%0d got=%h want=%h", issued, ram_addr_o, exp_addr[issued]);
                end
                issued++;
                last_addr_seen = ram_addr_o;
            end else if (ram_addr_o !== last_addr_seen) begin
                bad++;
                $display("FAIL addr_hold cyc=%0d got=%h want=%h", cyc, ram_addr_o, last_addr_seen);
            end

            if (held) begin
                total++;
                if (s_valid_o !== 1'b1 || s_re_o !== h_re || s_im_o !== h_im || s_last_o !== h_last) begin
                    bad++;
                    $display("FAIL stable cyc=%0d got v=%b %h/%h l=%b want v=1 %h/%h l=%b",
                             cyc, s_valid_o, s_re_o, s_im_o, s_last_o, h_re, h_im, h_last);
                end
            end
            held = 0;

            if (s_valid_o) begin
                if (first_valid < 0) first_valid = cyc;
                total++;
                if (popped >= n) begin
                    bad++;
                    $display("FAIL extra_sample cyc=%0d got=%h/%h required none", cyc, s_re_o, s_im_o);
                end else if (s_re_o !== exp_re[popped] || s_im_o !== exp_im[popped] ||
                             s_last_o !== 1'(popped == n - 1)) begin
                    bad++;
                    $display("FAIL sample k=%0d got=%h/%h last=%b want=%h/%h last=%b",
                             popped, s_re_o, s_im_o, s_last_o, exp_re[popped], exp_im[popped], (popped == n - 1));
                end
                if (s_ready_i) begin
                    popped++;
                    if (popped == n) last_hs = cyc;
                end else begin
                    held = 1; h_re = s_re_o; h_im = s_im_o; h_last = s_last_o;
                end
            end

            total++;
            if (issued - popped > DEPTH) begin
                bad++;
                $display("FAIL credit cyc=%0d outstanding=%0d required <=%0d", cyc, issued - popped, DEPTH);
            end

            if (done_o) begin
                total++;
                done_cyc = cyc;
                finished = 1;
                if (cyc != ((n == 0) ? 1 : last_hs + 1)) begin
                    bad++;
                    $display("FAIL done_time got=%0d want=%0d", cyc, (n == 0) ? 1 : last_hs + 1);
                end
            end
        end
        start_i = 1'b0;

        total++;
        if (!finished) begin
            bad++;
            $display("FAIL timeout count=%0d issued=%0d popped=%0d", n, issued, popped);
        end
        total++;
        if (issued != n || popped != n) begin
            bad++;
            $display("FAIL totals issued=%0d popped=%0d required %0d", issued, popped, n);
        end
        if (exact && n != 0) begin
            total++;
            if (first_en != 1 || first_valid != 3 || done_cyc != n + 3) begin
                bad++;
                $display("FAIL latency en=%0d valid=%0d done=%0d required 1 3 %0d", first_en, first_valid, done_cyc, n + 3);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        total++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || ram_en_o !== 1'b0 || s_valid_o !== 1'b0 ||
            s_last_o !== 1'b0 || ram_addr_o !== 16'h0 || s_re_o !== 16'h0 || s_im_o !== 16'h0) begin
            bad++;
            $display("FAIL %s busy=%b done=%b en=%b v=%b last=%b addr=%h re=%h im=%h required all 0",
                     tag, busy_o, done_o, ram_en_o, s_valid_o, s_last_o, ram_addr_o, s_re_o, s_im_o);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        check_reset_outputs("reset_values");
        rst = 1'b0;
        last_addr_seen = 16'h0;
    endtask

    task automatic test_basic();
        for (int k = 0; k < 4; k++) begin
            mem[16'h0100 + 16'(2 * k)]     = 16'(k);
            mem[16'h0100 + 16'(2 * k + 1)] = 16'h8000 + 16'(k);
        end
        run_block(16'h0100, 16'd4, 0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        run_block(16'h0400, 16'd8, 1, 1'b0, 1'b0);
    endtask

    task automatic test_zero_count();
        run_block(16'($urandom), 16'd0, 0, 1'b0, 1'b0);
        total++;
        if (got_addr.size() != 0) begin
            bad++;
            $display("FAIL zero_issue got=%0d required 0", got_addr.size());
        end
    endtask

    task automatic test_wrap();
        run_block(16'hFFFE, 16'd2, 0, 1'b1, 1'b0);
        total++;
        if (got_addr.size() != 2 || got_addr[0] !== 16'hFFFE || got_addr[1] !== 16'h0000) begin
            bad++;
            $display("FAIL wrap_addr got=%0d entries required FFFE,0000", got_addr.size());
        end
        run_block(16'hFFFF, 16'd2, 2, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_block();
        int n = 0;
        @(posedge clk); #1;
        start_i = 1'b1; base_i = 16'h2000; count_i = 16'd16; s_ready_i = 1'b1;
        for (int c = 0; c < 20 && n < 3; c++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            @(negedge clk);
            if (ram_en_o) n++;
        end
        total++;
        if (n != 3) begin
            bad++;
            $display("FAIL mid_issues got=%0d want=3", n);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_mid_block");
        @(negedge clk);
        rst = 1'b0;
        last_addr_seen = 16'h0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (done_o !== 1'b0 || ram_en_o !== 1'b0 || s_valid_o !== 1'b0 || busy_o !== 1'b0) begin
                bad++;
                $display("FAIL post_reset_idle done=%b en=%b v=%b busy=%b required 0", done_o, ram_en_o, s_valid_o, busy_o);
            end
        end
        run_block(16'h2000, 16'd16, 0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int b = 0; b < 6; b++) begin
            run_block(16'($urandom), 16'($urandom_range(1, 12)), 2, 1'b0, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        for (int b = 1; b <= 3; b++) begin
            run_block(16'($urandom), 16'(b), 0, 1'b1, 1'b0);
        end
    endtask

`ifdef FFT_STREAMER_BITREV_EN
    task automatic test_bitrev();
        logic [15:0] want [8] = '{16'd0, 16'd8, 16'd4, 16'd12, 16'd2, 16'd10, 16'd6, 16'd14};
        run_block(16'h0000, 16'd8, 0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (i >= got_addr.size() || got_addr[i] !== want[i]) begin
                bad++;
                $display("FAIL bitrev_addr i=%0d want=%h", i, want[i]);
            end
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        rst = 1'b1; start_i = 1'b0; base_i = 16'h0; count_i = 16'h0; s_ready_i = 1'b0;
        ram_a = 32'h0; ram_b = 32'h0; last_addr_seen = 16'h0;
        repeat (3) @(posedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_count();
        test_wrap();
        test_reset_mid_block();
        test_random();
        test_back_to_back();
`ifdef FFT_STREAMER_BITREV_EN
        test_bitrev();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
